// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the load/store path: RISC-V funct3 encodings for
// memory accesses, the load/store unit state encoding and the request
// legality check.
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RMW_RD = 3'd2,
      ST_STORE  = 3'd3,
      ST_RESP   = 3'd4
   } lsu_state_t;

   // A request is rejected when funct3 is unknown, a store asks for an
   // unsigned width, or the address is not naturally aligned for the width.
   function automatic logic lsu_req_err(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
      logic err;
      err = 1'b0;
      case (f3)
         F3_B:    err = 1'b0;
         F3_BU:   err = we;
         F3_H:    err = off[0];
         F3_HU:   err = we | off[0];
         F3_W:    err = (off != 2'b00);
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational byte-lane handling for the load/store unit.
//  - Load path: selects the byte/halfword lane addressed by off and applies
//    sign or zero extension according to funct3.
//  - Store path: merges the low-aligned store data into its lane of the word
//    read from memory (full replacement for word stores).
// Lanes are little-endian: lane k = data[8k+7:8k].
// Ports:
//  funct3     in  3       access width / signedness
//  off        in  2       byte offset within the word
//  mem_word   in  DATA_W  word read from memory
//  store_data in  DATA_W  low-aligned store data
//  load_data  out DATA_W  extended load result
//  merged     out DATA_W  word to write back for a store
// -----------------------------------------------------------------------------
module lsu_align
   import riscv_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        funct3,
   input  logic [1:0]        off,
   input  logic [DATA_W-1:0] mem_word,
   input  logic [DATA_W-1:0] store_data,
   output logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] merged
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane select for loads; halfwords are only legal at offsets 0 and 2.
   always_comb begin
      byte_s = mem_word[{off, 3'b000} +: 8];
      if (off[1]) begin
         half_s = mem_word[31:16];
      end else begin
         half_s = mem_word[15:0];
      end
   end

   // Extension of the selected lane for the load result.
   always_comb begin
      case (funct3)
         F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
         F3_BU:   load_data = {24'h000000, byte_s};
         F3_H:    load_data = {{16{half_s[15]}}, half_s};
         F3_HU:   load_data = {16'h0000, half_s};
         F3_W:    load_data = mem_word;
         default: load_data = 32'h0000_0000;
      endcase
   end

   // Insert the store data into its lane, keeping the other bytes intact.
   always_comb begin
      merged = mem_word;
      case (funct3)
         F3_B: merged[{off, 3'b000} +: 8] = store_data[7:0];
         F3_H: begin
            if (off[1]) begin
               merged[31:16] = store_data[15:0];
            end else begin
               merged[15:0] = store_data[15:0];
            end
         end
         F3_W:    merged = store_data;
         default: merged = mem_word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory initiator for the execute stage. Accepts one load/store request at a
// time, drives a word-wide memory (combinational read, write on next posedge),
// performs read-modify-write for byte/halfword stores and returns the extended
// load data or an error on a valid/ready response channel.
// Ports:
//  clk, rst_n                 clock, asynchronous active-low reset
//  req_valid_i / req_ready_o  request handshake (ready only when idle)
//  req_we_i, req_funct3_i     store flag, RISC-V access width encoding
//  req_addr_i, req_wdata_i    byte address, low-aligned store data
//  resp_valid_o/resp_ready_i  response handshake
//  resp_rdata_o, resp_err_o   load result (0 for stores/errors), error flag
//  MemRead, MemWrite          memory enables (never both high)
//  addr_o, write_data_o       word address (low bits zero), write word
//  read_data_i                memory read data
// -----------------------------------------------------------------------------
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [DATA_W-1:0] resp_rdata_o,
   output logic              resp_err_o,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] write_data_o,
   input  logic [DATA_W-1:0] read_data_i
);

   generate
      if (DATA_W != 32) begin : g_bad_data_w
         $error("load_store_unit: DATA_W must be 32");
      end
   endgenerate

   lsu_state_t        state_r;
   logic [2:0]        funct3_r;
   logic [1:0]        off_r;
   logic [DATA_W-1:0] wdata_r;
   logic [ADDR_W-3:0] bus_addr_r;
   logic [DATA_W-1:0] write_data_r;
   logic [DATA_W-1:0] resp_rdata_r;
   logic              resp_err_r;
   logic              req_err_s;
   logic [DATA_W-1:0] load_data_s;
   logic [DATA_W-1:0] merged_s;

   assign req_err_s = lsu_req_err(req_we_i, req_funct3_i, req_addr_i[1:0]);

   lsu_align #(.DATA_W(DATA_W)) u_align (
      .funct3     (funct3_r),
      .off        (off_r),
      .mem_word   (read_data_i),
      .store_data (wdata_r),
      .load_data  (load_data_s),
      .merged     (merged_s)
   );

   // Request/response FSM. The bus address is only updated by requests that
   // will touch memory, so errored requests leave addr_o unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         funct3_r     <= 3'b000;
         off_r        <= 2'b00;
         wdata_r      <= '0;
         bus_addr_r   <= '0;
         write_data_r <= '0;
         resp_rdata_r <= '0;
         resp_err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid_i) begin
                  funct3_r     <= req_funct3_i;
                  off_r        <= req_addr_i[1:0];
                  wdata_r      <= req_wdata_i;
                  resp_rdata_r <= '0;
                  resp_err_r   <= req_err_s;
                  if (req_err_s) begin
                     state_r <= ST_RESP;
                  end else begin
                     bus_addr_r <= req_addr_i[ADDR_W-1:2];
                     if (!req_we_i) begin
                        state_r <= ST_LOAD;
                     end else if (req_funct3_i == F3_W) begin
                        write_data_r <= req_wdata_i;
                        state_r      <= ST_STORE;
                     end else begin
                        state_r <= ST_RMW_RD;
                     end
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               resp_rdata_r <= load_data_s;
               state_r      <= ST_RESP;
            end
            ST_RMW_RD: begin
               write_data_r <= merged_s;
               state_r      <= ST_STORE;
            end
            ST_STORE: begin
               state_r <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready_i) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_RESP;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Handshake and memory enables are a pure decode of the state register so
   // an asynchronous reset removes MemWrite immediately.
   assign req_ready_o  = (state_r == ST_IDLE);
   assign resp_valid_o = (state_r == ST_RESP);
   assign MemRead      = (state_r == ST_LOAD) || (state_r == ST_RMW_RD);
   assign MemWrite     = (state_r == ST_STORE);
   assign addr_o       = {bus_addr_r, 2'b00};
   assign write_data_o = write_data_r;
   assign resp_rdata_o = resp_rdata_r;
   assign resp_err_o   = resp_err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit paired with a small word memory model.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] addr_o;
   logic [31:0] write_data_o;
   logic [31:0] read_data_i;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:63];
   logic        mem_clear;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_we_i     (req_we_i),
      .req_funct3_i (req_funct3_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_rdata_o (resp_rdata_o),
      .resp_err_o   (resp_err_o),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .addr_o       (addr_o),
      .write_data_o (write_data_o),
      .read_data_i  (read_data_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // data_memory model: combinational read, write on posedge.
   assign read_data_i = mem[addr_o[7:2]];
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      end else if (MemWrite) begin
         mem[addr_o[7:2]] <= write_data_o;
      end
   end

   // Drives one request and completes its response; reports latency and bus activity.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output int rdc, output int wrc,
                         output logic [31:0] wdo, output logic [31:0] wao);
      lat = 0; rdc = 0; wrc = 0; wdo = 32'h0; wao = 32'h0; rd = 32'h0; er = 1'b0;
      @(negedge clk);
      req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
      req_addr_i = addr; req_wdata_i = wd;
      @(posedge clk);
      for (int cnt = 0; cnt < 10; cnt++) begin
         @(negedge clk);
         req_valid_i = 1'b0;
         if (MemRead) rdc++;
         if (MemWrite) begin
            wrc++; wdo = write_data_o; wao = addr_o;
         end
         if (resp_valid_o) begin
            lat = cnt + 1; rd = resp_rdata_o; er = resp_err_o;
            break;
         end
         @(posedge clk);
      end
      if (lat != 0) begin
         resp_ready_i = 1'b1;
         @(posedge clk);
         @(negedge clk);
         resp_ready_i = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (resp_valid_o !== 1'b0 || resp_err_o !== 1'b0 || resp_rdata_o !== 32'h0 ||
          MemRead !== 1'b0 || MemWrite !== 1'b0) begin
         errors++;
         $display("FAIL reset_resp_mem: valid=%b err=%b rdata=%h rd=%b wr=%b, required all 0",
                  resp_valid_o, resp_err_o, resp_rdata_o, MemRead, MemWrite);
      end
      checks++;
      if (addr_o !== 32'h0 || write_data_o !== 32'h0 || req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_bus: addr=%h wdata=%h ready=%b, required 0/0/1",
                  addr_o, write_data_o, req_ready_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mem_clear = 1'b0;
   endtask

   task automatic test_word();
      logic [31:0] rd, wdo, wao; logic er; int lat, rdc, wrc;
      do_req(1'b1, 3'b010, 32'd8, 32'hAABBCCDD, rd, er, lat, rdc, wrc, wdo, wao);
      checks++;
      if (lat !== 2 || wrc !== 1 || rdc !== 0 || wao !== 32'd8 || wdo !== 32'hAABBCCDD || er !== 1'b0) begin
         errors++;
         $display("FAIL sw8: lat=%0d wr=%0d rd=%0d addr=%h data=%h err=%b, required 2/1/0/8/aabbccdd/0",
                  lat, wrc, rdc, wao, wdo, er);
      end
      do_req(1'b0, 3'b010, 32'd8, 32'h0, rd, er, lat, rdc, wrc, wdo, wao);
      checks++;
      if (rd !== 32'hAABBCCDD || er !== 1'b0 || lat !== 2 || rdc !== 1 || wrc !== 0) begin
         errors++;
         $display("FAIL lw8: rdata=%h err=%b lat=%0d rd=%0d wr=%0d, required aabbccdd/0/2/1/0",
                  rd, er, lat, rdc, wrc);
      end
   endtask

   task automatic test_subword_load();
      logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
      logic [31:0] ads [5] = '{32'd9, 32'd9, 32'd10, 32'd10, 32'd8};
      logic [31:0] exs [5] = '{32'hFFFFFFCC, 32'h000000CC, 32'hFFFFAABB, 32'h0000AABB, 32'hFFFFFFDD};
      logic [31:0] rd, wdo, wao; logic er; int lat, rdc, wrc;
      for (int i = 0; i < 5; i++) begin
         do_req(1'b0, f3s[i], ads[i], 32'h0, rd, er, lat, rdc, wrc, wdo, wao);
         checks++;
         if (rd !== exs[i] || er !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL load_lane_%0d: rdata=%h err=%b lat=%0d, required %h/0/2",
                     i, rd, er, lat, exs[i]);
         end
      end
   endtask

   task automatic test_rmw();
      logic [31:0] rd, wdo, wao; logic er; int lat, rdc, wrc;
      do_req(1'b1, 3'b010, 32'd12, 32'h12345678, rd, er, lat, rdc, wrc, wdo, wao);
      do_req(1'b1, 3'b000, 32'd13, 32'h00000011, rd, er, lat, rdc, wrc, wdo, wao);
      checks++;
      if (wdo !== 32'h12341178 || rdc !== 1 || wrc !== 1 || lat !== 3 || wao !== 32'd12 || rd !== 32'h0) begin
         errors++;
         $display("FAIL sb13: data=%h rd=%0d wr=%0d lat=%0d addr=%h rdata=%h, required 12341178/1/1/3/c/0",
                  wdo, rdc, wrc, lat, wao, rd);
      end
      do_req(1'b1, 3'b001, 32'd14, 32'h0000BEEF, rd, er, lat, rdc, wrc, wdo, wao);
      checks++;
      if (wdo !== 32'hBEEF1178 || wrc !== 1 || lat !== 3) begin
         errors++;
         $display("FAIL sh14: data=%h wr=%0d lat=%0d, required beef1178/1/3", wdo, wrc, lat);
      end
      do_req(1'b0, 3'b010, 32'd12, 32'h0, rd, er, lat, rdc, wrc, wdo, wao);
      checks++;
      if (rd !== 32'hBEEF1178 || er !== 1'b0) begin
         errors++;
         $display("FAIL lw12: rdata=%h err=%b, required beef1178/0", rd, er);
      end
   endtask

   task automatic test_errors();
      logic        wes [3] = '{1'b0, 1'b1, 1'b1};
      logic [2:0]  f3s [3] = '{3'b010, 3'b001, 3'b100};
      logic [31:0] ads [3] = '{32'd14, 32'd11, 32'd16};
      logic [31:0] rd, wdo, wao; logic er; int lat, rdc, wrc;
      for (int i = 0; i < 3; i++) begin
         do_req(wes[i], f3s[i], ads[i], 32'hFFFFFFFF, rd, er, lat, rdc, wrc, wdo, wao);
         checks++;
         if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || rdc !== 0 || wrc !== 0) begin
            errors++;
            $display("FAIL err_%0d: err=%b rdata=%h lat=%0d rd=%0d wr=%0d, required 1/0/1/0/0",
                     i, er, rd, lat, rdc, wrc);
         end
      end
      checks++;
      if (addr_o !== 32'd12) begin
         errors++;
         $display("FAIL err_bus_addr: addr=%h, required c", addr_o);
      end
   endtask

   task automatic test_resp_hold();
      logic [31:0] rd, wdo, wao; logic er; int lat, rdc, wrc;
      int seen;
      int wr_seen;
      seen = 0; wr_seen = 0;
      @(negedge clk);
      req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'd8;
      @(posedge clk);
      for (int c = 0; c < 10 && seen == 0; c++) begin
         @(negedge clk);
         req_valid_i = 1'b0;
         if (resp_valid_o) seen = 1;
         else @(posedge clk);
      end
      checks++;
      if (seen == 0) begin
         errors++;
         $display("FAIL hold_resp_timeout: resp_valid never rose, required within 10 cycles");
      end
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         checks++;
         if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'hAABBCCDD || resp_err_o !== 1'b0 || req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle_%0d: valid=%b rdata=%h err=%b ready=%b, required 1/aabbccdd/0/0",
                     c, resp_valid_o, resp_rdata_o, resp_err_o, req_ready_o);
         end
         if (MemWrite) wr_seen++;
         req_valid_i = (c == 0); req_we_i = 1'b1; req_funct3_i = 3'b010; req_wdata_i = 32'h55;
         @(posedge clk);
      end
      @(negedge clk);
      req_valid_i = 1'b0;
      if (MemWrite) wr_seen++;
      resp_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready_i = 1'b0;
      checks++;
      if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || wr_seen != 0) begin
         errors++;
         $display("FAIL hold_release: valid=%b ready=%b writes=%0d, required 0/1/0",
                  resp_valid_o, req_ready_o, wr_seen);
      end
      do_req(1'b0, 3'b010, 32'd8, 32'h0, rd, er, lat, rdc, wrc, wdo, wao);
      checks++;
      if (rd !== 32'hAABBCCDD) begin
         errors++;
         $display("FAIL hold_ignored_req: rdata=%h, required aabbccdd", rd);
      end
   endtask

   task automatic test_reset_mid_store();
      logic [31:0] rd, wdo, wao; logic er; int lat, rdc, wrc;
      @(negedge clk);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010;
      req_addr_i = 32'd20; req_wdata_i = 32'hDEADBEEF;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      checks++;
      if (MemWrite !== 1'b1 || addr_o !== 32'd20) begin
         errors++;
         $display("FAIL store_cycle: MemWrite=%b addr=%h, required 1/14", MemWrite, addr_o);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (MemWrite !== 1'b0 || MemRead !== 1'b0 || req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 ||
          addr_o !== 32'h0 || write_data_o !== 32'h0 || resp_rdata_o !== 32'h0 || resp_err_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs: wr=%b rd=%b ready=%b valid=%b addr=%h wdata=%h rdata=%h err=%b, required 0/0/1/0/0/0/0/0",
                  MemWrite, MemRead, req_ready_o, resp_valid_o, addr_o, write_data_o, resp_rdata_o, resp_err_o);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      do_req(1'b0, 3'b010, 32'd20, 32'h0, rd, er, lat, rdc, wrc, wdo, wao);
      checks++;
      if (rd !== 32'h0 || er !== 1'b0 || lat !== 2) begin
         errors++;
         $display("FAIL lw20_after_reset: rdata=%h err=%b lat=%0d, required 0/0/2", rd, er, lat);
      end
   endtask

   initial begin
      rst_n = 1'b0; mem_clear = 1'b1;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b000;
      req_addr_i = 32'h0; req_wdata_i = 32'h0; resp_ready_i = 1'b0;
      test_reset();
      test_word();
      test_subword_load();
      test_rmw();
      test_errors();
      test_resp_hold();
      test_reset_mid_store();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
